// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction fetch stage feeding decode.
// Owns the PC, reads the combinational instruction ROM at rom_addr and
// captures {pc, instr} pairs into a DEPTH-entry prefetch FIFO. Decode pops
// the head over a valid/ready handshake. A redirect flushes the FIFO and
// restarts fetch at the word-aligned target.
//
// Handshake: an entry moves to decode on a rising edge where if_valid=1 and
// if_ready=1. While if_valid=1 and if_ready=0, if_pc/if_instr hold steady.
// if_valid never depends on if_ready in the same cycle.
//
// Optional feature macro: FETCH_PERF_EN adds perf_bubble_cnt, a saturating
// count of cycles where decode was ready but no instruction was available.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_bubble_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [PW-1:0] P_ONE   = PW'(1);

  logic [31:0]   pc;
  logic [31:0]   mem_pc    [DEPTH];
  logic [31:0]   mem_instr [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          pop;
  logic          push;

  assign rom_addr = pc;
  assign if_valid = (count != '0);
  assign pop      = if_valid & if_ready;
  // A full FIFO still accepts a new entry when the head leaves this cycle.
  assign push     = !redirect & ((count < DEPTH_C) | pop);

  // Head outputs read zero when the FIFO is empty so stale data never leaks.
  always_comb begin
    if_instr = 32'h0;
    if_pc    = 32'h0;
    if (if_valid) begin
      if_instr = mem_instr[rd_ptr];
      if_pc    = mem_pc[rd_ptr];
    end
  end

  // Program counter: advance on each capture, jump on redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= {redirect_pc[31:2], 2'b00};
    end else if (push) begin
      pc <= pc + 32'd4;
    end
  end

  // FIFO storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]    <= pc;
      mem_instr[wr_ptr] <= rom_data;
    end
  end

  // Pointers and occupancy; redirect and reset both empty the FIFO.
  always_ff @(posedge clk) begin
    if (reset || redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + P_ONE;
      if (pop)  rd_ptr <= rd_ptr + P_ONE;
      case ({push, pop})
        2'b10:   count <= count + C_ONE;
        2'b01:   count <= count - C_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  // Bubble counter: decode ready with nothing to take; saturates, reset-only clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_bubble_cnt <= 32'h0;
    end else if (if_ready && !if_valid && (perf_bubble_cnt != 32'hFFFF_FFFF)) begin
      perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule
